// File: rtl/voice_mix_engine.sv
// voice_mix_engine: per-frame voice mixer.
// On each rising edge of trig it scans every voice in order. Each voice sample is
// multiplied by a per-channel unsigned gain and added into a wide per-channel
// accumulator. At the end of the frame each accumulator is shifted right, saturated
// and registered onto sound_out, and frame_done pulses for one cycle.
// Ports:
//   AUDIO_CLK     clock
//   reset_data    synchronous active-high reset
//   trig          sample trigger; a frame starts on its rising edge
//   voice_active  per-voice enable; 0 makes the voice contribute zero
//   voice_addr    voice index being read
//   voice_rd      read strobe; the source returns data one cycle later
//   voice_sample  signed sample for last cycle's address
//   voice_gain    per-channel gains for that voice, aligned with voice_sample
//   overrun_clr   clears the overrun flag
//   sound_out     registered mix, channel c at [c*OUT_WIDTH +: OUT_WIDTH]
//   frame_done    one-cycle pulse when sound_out updates
//   busy          high from frame start until frame_done
//   overrun       sticky; set when a trigger edge arrives while busy
module voice_mix_engine #(
    parameter int unsigned VOICES     = 32,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned IN_WIDTH   = 24,
    parameter int unsigned GAIN_WIDTH = 8,
    parameter int unsigned OUT_WIDTH  = 24,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned AW         = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                           AUDIO_CLK,
    input  logic                           reset_data,
    input  logic                           trig,
    input  logic [VOICES-1:0]              voice_active,
    output logic [AW-1:0]                  voice_addr,
    output logic                           voice_rd,
    input  logic [IN_WIDTH-1:0]            voice_sample,
    input  logic [CHANNELS*GAIN_WIDTH-1:0] voice_gain,
    input  logic                           overrun_clr,
    output logic [CHANNELS*OUT_WIDTH-1:0]  sound_out,
    output logic                           frame_done,
    output logic                           busy,
    output logic                           overrun
);

    localparam int unsigned PROD_W = IN_WIDTH + GAIN_WIDTH + 1;
    localparam int unsigned ACC_W  = IN_WIDTH + GAIN_WIDTH + AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_SCALE = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_trig_q;
    logic                        w_start;
    logic [AW-1:0]               r_addr_q;
    logic                        r_rd_q;
    logic signed [ACC_W-1:0]     r_acc [CHANNELS];
    logic signed [PROD_W-1:0]    w_prod [CHANNELS];
    logic signed [ACC_W-1:0]     w_shift [CHANNELS];
    logic [CHANNELS*OUT_WIDTH-1:0] w_sat;
    logic [AW-1:0]               w_addr_nxt;
    logic                        w_rd_nxt;
    logic                        w_busy_nxt;
    logic                        w_done_nxt;
    logic                        w_acc_clr;
    logic                        w_load_out;

    assign w_start = trig & ~r_trig_q;

    // Next-state and registered-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = voice_addr;
        w_rd_nxt    = voice_rd;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;
        w_acc_clr   = 1'b0;
        w_load_out  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_FETCH;
                    w_addr_nxt  = '0;
                    w_rd_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_acc_clr   = 1'b1;
                end
            end
            S_FETCH: begin
                if (voice_addr == LAST_ADDR) begin
                    w_rd_nxt    = 1'b0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_addr_nxt = voice_addr + AW'(1);
                end
            end
            S_DRAIN: w_state_nxt = S_SCALE;
            S_SCALE: begin
                w_load_out  = 1'b1;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-channel product, shift and saturation
    always_comb begin
        w_sat = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_prod[c]  = PROD_W'($signed(voice_sample)) *
                         PROD_W'($signed({1'b0, voice_gain[c*GAIN_WIDTH +: GAIN_WIDTH]}));
            w_shift[c] = r_acc[c] >>> SHIFT;
            if (w_shift[c] > SAT_MAX) begin
                w_sat[c*OUT_WIDTH +: OUT_WIDTH] = SAT_MAX[OUT_WIDTH-1:0];
            end else if (w_shift[c] < SAT_MIN) begin
                w_sat[c*OUT_WIDTH +: OUT_WIDTH] = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                w_sat[c*OUT_WIDTH +: OUT_WIDTH] = w_shift[c][OUT_WIDTH-1:0];
            end
        end
    end

    // State, control outputs and overrun flag
    always_ff @(posedge AUDIO_CLK) begin
        if (reset_data) begin
            r_state    <= S_IDLE;
            r_trig_q   <= 1'b0;
            r_addr_q   <= '0;
            r_rd_q     <= 1'b0;
            voice_addr <= '0;
            voice_rd   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            sound_out  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_trig_q   <= trig;
            // Delayed address tracks the voice whose data is arriving this cycle
            r_addr_q   <= voice_addr;
            r_rd_q     <= voice_rd;
            voice_addr <= w_addr_nxt;
            voice_rd   <= w_rd_nxt;
            busy       <= w_busy_nxt;
            frame_done <= w_done_nxt;
            // A set in the same cycle as a clear takes priority
            if (w_start && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (w_load_out) begin
                sound_out <= w_sat;
            end
        end
    end

    // Accumulators; each is wide enough that a full frame never wraps
    always_ff @(posedge AUDIO_CLK) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (reset_data || w_acc_clr) begin
                r_acc[c] <= '0;
            end else if (r_rd_q && voice_active[r_addr_q]) begin
                r_acc[c] <= r_acc[c] + ACC_W'(w_prod[c]);
            end
        end
    end

endmodule

// File: tb/tb_voice_mix_engine.sv
module tb_voice_mix_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_data;
    logic        trig;
    logic        overrun_clr;
    logic [3:0]  voice_active;
    logic [1:0]  voice_addr;
    logic        voice_rd;
    logic [23:0] voice_sample;
    logic [15:0] voice_gain;
    logic [47:0] sound_out;
    logic        frame_done;
    logic        busy;
    logic        overrun;

    logic [0:0]  g_active;
    logic [0:0]  g_addr;
    logic        g_rd;
    logic [23:0] g_sample;
    logic [31:0] g_gain;
    logic [63:0] g_out;
    logic        g_done;
    logic        g_busy;
    logic        g_ovr;

    logic [23:0] mem_s [4];
    logic [15:0] mem_g [4];
    logic [23:0] g_mem_s;
    logic [31:0] g_mem_g;

    int n_tests = 0;
    int n_fail  = 0;

    int rd_log [16];
    int addr_log [16];
    int done_log [16];
    int busy_log [16];
    int ovr_log [16];
    int g_done_log [16];

    voice_mix_engine #(.VOICES(4)) dut (
        .AUDIO_CLK(clk), .reset_data(reset_data), .trig(trig),
        .voice_active(voice_active), .voice_addr(voice_addr), .voice_rd(voice_rd),
        .voice_sample(voice_sample), .voice_gain(voice_gain), .overrun_clr(overrun_clr),
        .sound_out(sound_out), .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    voice_mix_engine #(.VOICES(1), .CHANNELS(4), .OUT_WIDTH(16), .SHIFT(16)) dut_gen (
        .AUDIO_CLK(clk), .reset_data(reset_data), .trig(trig),
        .voice_active(g_active), .voice_addr(g_addr), .voice_rd(g_rd),
        .voice_sample(g_sample), .voice_gain(g_gain), .overrun_clr(overrun_clr),
        .sound_out(g_out), .frame_done(g_done), .busy(g_busy), .overrun(g_ovr)
    );

    // Voice store model: one-cycle read latency, junk when not read
    always @(posedge clk) begin
        if (voice_rd) begin
            voice_sample <= mem_s[voice_addr];
            voice_gain   <= mem_g[voice_addr];
        end else begin
            voice_sample <= 24'h5A5A5A;
            voice_gain   <= 16'hFFFF;
        end
        if (g_rd) begin
            g_sample <= g_mem_s;
            g_gain   <= g_mem_g;
        end else begin
            g_sample <= 24'h5A5A5A;
            g_gain   <= 32'hFFFF_FFFF;
        end
    end

    task automatic set_all(input logic [23:0] s, input logic [7:0] g0, input logic [7:0] g1);
        for (int v = 0; v < 4; v++) begin
            mem_s[v] = s;
            mem_g[v] = {g1, g0};
        end
        voice_active = 4'b1111;
    endtask

    // Trigger edge in cycle T (offset 0) and log 16 cycles; events at given offsets
    task automatic run_frame(input int hold, input int second_at, input int clr_at, input int rst_at);
        @(posedge clk); #1;
        trig = 1'b1;
        for (int off = 0; off < 16; off++) begin
            @(negedge clk);
            rd_log[off]     = int'(voice_rd);
            addr_log[off]   = int'(voice_addr);
            done_log[off]   = int'(frame_done);
            busy_log[off]   = int'(busy);
            ovr_log[off]    = int'(overrun);
            g_done_log[off] = int'(g_done);
            @(posedge clk); #1;
            reset_data  = (off + 1 == rst_at);
            overrun_clr = (off + 1 == clr_at);
            if (off + 1 == hold) trig = 1'b0;
            if (off + 1 == second_at) trig = 1'b1;
        end
        trig        = 1'b0;
        reset_data  = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_data = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({sound_out, frame_done, busy, overrun, voice_rd, voice_addr} !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {sound_out, frame_done, busy, overrun, voice_rd, voice_addr});
        end
        n_tests++;
        if (g_out !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_gen_out: got %h required 0", g_out);
        end
        @(posedge clk); #1;
        reset_data = 1'b0;
    endtask

    task automatic test_unity_pan();
        int first;
        int cnt;
        int nrd;
        set_all(24'h100000, 8'd128, 8'd128);
        run_frame(12, -1, -1, -1);
        first = -1; cnt = 0; nrd = 0;
        for (int off = 0; off < 16; off++) begin
            if (done_log[off] != 0) begin
                cnt++;
                if (first < 0) first = off;
            end
            nrd += rd_log[off];
        end
        n_tests++;
        if (first !== 7 || cnt !== 1) begin
            n_fail++;
            $display("FAIL unity_done_time: got offset %0d count %0d required offset 7 count 1", first, cnt);
        end
        n_tests++;
        if (nrd !== 4) begin
            n_fail++;
            $display("FAIL unity_rd_cycles: got %0d required 4", nrd);
        end
        for (int off = 1; off <= 4; off++) begin
            n_tests++;
            if (rd_log[off] !== 1 || addr_log[off] !== off - 1) begin
                n_fail++;
                $display("FAIL unity_addr_T+%0d: got rd %0d addr %0d required rd 1 addr %0d", off, rd_log[off], addr_log[off], off - 1);
            end
        end
        n_tests++;
        if (busy_log[1] !== 1 || busy_log[6] !== 1 || busy_log[7] !== 0 || busy_log[13] !== 0) begin
            n_fail++;
            $display("FAIL unity_busy: got T+1=%0d T+6=%0d T+7=%0d T+13=%0d required 1 1 0 0", busy_log[1], busy_log[6], busy_log[7], busy_log[13]);
        end
        n_tests++;
        if (sound_out !== {24'h200000, 24'h200000}) begin
            n_fail++;
            $display("FAIL unity_mix: got %h required %h", sound_out, {24'h200000, 24'h200000});
        end
    endtask

    task automatic test_saturation();
        set_all(24'h7FFFFF, 8'd255, 8'd255);
        run_frame(1, -1, -1, -1);
        n_tests++;
        if (sound_out !== {24'h7FFFFF, 24'h7FFFFF}) begin
            n_fail++;
            $display("FAIL sat_pos: got %h required %h", sound_out, {24'h7FFFFF, 24'h7FFFFF});
        end
        set_all(24'h800000, 8'd255, 8'd255);
        run_frame(1, -1, -1, -1);
        n_tests++;
        if (sound_out !== {24'h800000, 24'h800000}) begin
            n_fail++;
            $display("FAIL sat_neg: got %h required %h", sound_out, {24'h800000, 24'h800000});
        end
    endtask

    task automatic test_mask_pan();
        set_all(24'h7FFFFF, 8'd255, 8'd255);
        mem_s[2] = 24'h000400;
        mem_g[2] = {8'd192, 8'd64};
        voice_active = 4'b0100;
        run_frame(1, -1, -1, -1);
        n_tests++;
        if (sound_out !== {24'h000300, 24'h000100}) begin
            n_fail++;
            $display("FAIL mask_pan: got %h required %h", sound_out, {24'h000300, 24'h000100});
        end
    endtask

    task automatic test_negative();
        // -1 * 128 * 4 = -512, shifted by 8 gives -2; ch1 gain 0 gives 0
        set_all(24'hFFFFFF, 8'd128, 8'd0);
        run_frame(1, -1, -1, -1);
        n_tests++;
        if (sound_out !== {24'h000000, 24'hFFFFFE}) begin
            n_fail++;
            $display("FAIL negative_mix: got %h required %h", sound_out, {24'h000000, 24'hFFFFFE});
        end
    endtask

    task automatic test_overrun();
        int first;
        int cnt;
        set_all(24'h100000, 8'd128, 8'd128);
        run_frame(1, 3, -1, -1);
        first = -1; cnt = 0;
        for (int off = 0; off < 16; off++) begin
            if (done_log[off] != 0) begin
                cnt++;
                if (first < 0) first = off;
            end
        end
        n_tests++;
        if (ovr_log[3] !== 0 || ovr_log[4] !== 1) begin
            n_fail++;
            $display("FAIL overrun_set: got T+3=%0d T+4=%0d required 0 1", ovr_log[3], ovr_log[4]);
        end
        n_tests++;
        if (first !== 7 || cnt !== 1) begin
            n_fail++;
            $display("FAIL overrun_done: got offset %0d count %0d required offset 7 count 1", first, cnt);
        end
        n_tests++;
        if (sound_out !== {24'h200000, 24'h200000}) begin
            n_fail++;
            $display("FAIL overrun_mix: got %h required %h", sound_out, {24'h200000, 24'h200000});
        end
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b required 1", overrun);
        end
        @(posedge clk); #1;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
        run_frame(1, 3, 3, -1);
        n_tests++;
        if (ovr_log[4] !== 1) begin
            n_fail++;
            $display("FAIL overrun_set_wins: got %0d required 1", ovr_log[4]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cnt;
        set_all(24'h100000, 8'd128, 8'd128);
        run_frame(1, -1, -1, 4);
        cnt = 0;
        for (int off = 0; off < 16; off++) cnt += done_log[off];
        n_tests++;
        if (cnt !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d pulses required 0", cnt);
        end
        n_tests++;
        if (busy_log[4] !== 1 || busy_log[5] !== 0) begin
            n_fail++;
            $display("FAIL midreset_busy: got T+4=%0d T+5=%0d required 1 0", busy_log[4], busy_log[5]);
        end
        n_tests++;
        if (sound_out !== 48'd0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_out: got out %h ovr %b required 0 0", sound_out, overrun);
        end
        run_frame(1, -1, -1, -1);
        n_tests++;
        if (done_log[7] !== 1 || sound_out !== {24'h200000, 24'h200000}) begin
            n_fail++;
            $display("FAIL midreset_recover: got done %0d out %h required 1 %h", done_log[7], sound_out, {24'h200000, 24'h200000});
        end
    endtask

    task automatic test_generality();
        int first;
        int cnt;
        g_mem_s  = 24'h400000;
        g_mem_g  = {8'd0, 8'd64, 8'd128, 8'd255};
        g_active = 1'b1;
        run_frame(1, -1, -1, -1);
        first = -1; cnt = 0;
        for (int off = 0; off < 16; off++) begin
            if (g_done_log[off] != 0) begin
                cnt++;
                if (first < 0) first = off;
            end
        end
        n_tests++;
        if (first !== 4 || cnt !== 1) begin
            n_fail++;
            $display("FAIL gen_done_time: got offset %0d count %0d required offset 4 count 1", first, cnt);
        end
        n_tests++;
        if (g_out !== {16'h0000, 16'h1000, 16'h2000, 16'h3FC0}) begin
            n_fail++;
            $display("FAIL gen_mix: got %h required %h", g_out, {16'h0000, 16'h1000, 16'h2000, 16'h3FC0});
        end
    endtask

    initial begin
        reset_data   = 1'b1;
        trig         = 1'b0;
        overrun_clr  = 1'b0;
        voice_active = 4'b0000;
        g_active     = 1'b0;
        g_mem_s      = '0;
        g_mem_g      = '0;
        set_all(24'h0, 8'd0, 8'd0);
        test_reset();
        test_unity_pan();
        test_saturation();
        test_mask_pan();
        test_negative();
        test_overrun();
        test_reset_mid_frame();
        test_generality();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
